// File: rtl/counter_cmd_seq.sv
// Command sequencer driving an up/down preloadable counter (LOAD / UP-n / DOWN-n).
// Optional abort input enabled by defining CNTSEQ_ABORT_EN.
`timescale 1ns/1ps
module counter_cmd_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEPW = 8
) (
  input  logic             clk,
  input  logic             _areset,
`ifdef CNTSEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic             cmd_wrap,
  input  logic [WIDTH-1:0] ctr_dcout,
  output logic             ctr_load_n,
  output logic [WIDTH-1:0] ctr_preld,
  output logic             ctr_updown,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  localparam logic [1:0]       OP_LOAD  = 2'b01;
  localparam logic [1:0]       OP_UP    = 2'b10;
  localparam logic [1:0]       OP_DOWN  = 2'b11;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [STEPW-1:0] ZERO_STP = {STEPW{1'b0}};
  localparam logic [STEPW-1:0] ONE_STEP = STEPW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [STEPW-1:0] remain_q, remain_d;
  logic             wrap_q, wrap_d;
  logic             sat_d;
  logic             at_limit;
  logic             abort_c;

`ifdef CNTSEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // State, captured command and registered status outputs
  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      state_q   <= ST_IDLE;
      op_q      <= 2'b00;
      arg_q     <= ZERO_VAL;
      remain_q  <= ZERO_STP;
      wrap_q    <= 1'b0;
      sat       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      remain_q  <= remain_d;
      wrap_q    <= wrap_d;
      sat       <= sat_d;
      done      <= (state_d == ST_DONE);
      busy      <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      cmd_ready <= (state_d == ST_IDLE);
    end
  end

  // Next state and counter pin drive; freeze (reload dcout) is the default
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_d      = arg_q;
    remain_d   = remain_q;
    wrap_d     = wrap_q;
    sat_d      = sat;
    ctr_load_n = 1'b0;
    ctr_preld  = ctr_dcout;
    ctr_updown = (op_q == OP_UP);
    at_limit   = (op_q == OP_UP) ? (ctr_dcout == ALL_ONES) : (ctr_dcout == ZERO_VAL);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d     = cmd_op;
          arg_d    = cmd_arg;
          remain_d = cmd_steps;
          wrap_d   = cmd_wrap;
          sat_d    = 1'b0;
          case (cmd_op)
            OP_LOAD:        state_d = ST_LOAD;
            OP_UP, OP_DOWN: state_d = (cmd_steps == ZERO_STP) ? ST_DONE : ST_RUN;
            default:        state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        state_d = ST_DONE;
        if (!abort_c) ctr_preld = arg_q;
      end
      ST_RUN: begin
        if (abort_c) begin
          state_d = ST_DONE;
        end else if (!wrap_q && at_limit) begin
          // Hold at the limit instead of taking the count that would pass it
          sat_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          ctr_load_n = 1'b1;
          remain_d   = remain_q - ONE_STEP;
          if (remain_q == ONE_STEP) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench for counter_cmd_seq with a behavioural counter and an
// arithmetic per-command reference model; randomized command stream.
`timescale 1ns/1ps
module tb_counter_cmd_seq;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic [7:0] cmd_steps = 8'h00;
  logic       cmd_wrap = 1'b0;
  logic [7:0] ctr_dcout;
  logic       ctr_load_n;
  logic [7:0] ctr_preld;
  logic       ctr_updown;
  logic       busy, done, sat;
`ifdef CNTSEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic [7:0] cnt = 8'h00;
  int checks = 0;
  int errors = 0;
  int mval   = 0;

  counter_cmd_seq #(.WIDTH(8), .STEPW(8)) dut (
    .clk       (clk),
    ._areset   (areset_n),
`ifdef CNTSEQ_ABORT_EN
    .abort     (abort),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_steps (cmd_steps),
    .cmd_wrap  (cmd_wrap),
    .ctr_dcout (ctr_dcout),
    .ctr_load_n(ctr_load_n),
    .ctr_preld (ctr_preld),
    .ctr_updown(ctr_updown),
    .busy      (busy),
    .done      (done),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  // Behavioural up/down preloadable counter
  assign ctr_dcout = cnt;
  always @(posedge clk) begin
    if (!ctr_load_n)    cnt <= ctr_preld;
    else if (ctr_updown) cnt <= cnt + 8'd1;
    else                cnt <= cnt - 8'd1;
  end

  // Expected outcome of one command from the starting counter value v
  function automatic void model(input logic [1:0] op, input int v, input int arg,
                                input int steps, input bit wrap, input int ab,
                                output int lat, output int nb, output int fin,
                                output bit s);
    int lim, runc, cnts;
    s = 1'b0; fin = v; lat = 1; nb = 0;
    if (op == 2'b01) begin
      lat = 2; nb = 1; fin = arg;
    end else if (op[1] && steps > 0) begin
      lim = (op == 2'b10) ? 255 - v : v;
      if (!wrap && steps > lim) begin
        cnts = lim; runc = lim + 1; s = 1'b1;
      end else begin
        cnts = steps; runc = steps;
      end
      if (ab > 0 && ab <= runc) begin
        cnts = ab - 1; runc = ab; s = 1'b0;
      end
      fin = (op == 2'b10) ? (v + cnts) % 256 : (v - cnts + 256) % 256;
      lat = runc + 1;
      nb  = runc;
    end
  endfunction

  task automatic exec_cmd(input string name, input logic [1:0] op, input logic [7:0] arg,
                          input logic [7:0] steps, input bit wrap, input int ab_in,
                          input bit noise);
    int e_lat, e_nb, e_fin, lat, nb, ab;
    bit e_sat, seen;
    ab = ab_in;
`ifndef CNTSEQ_ABORT_EN
    ab = 0;
`endif
    model(op, mval, int'(arg), int'(steps), wrap, ab, e_lat, e_nb, e_fin, e_sat);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_steps = steps; cmd_wrap = wrap;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b00;
    lat = 0; nb = 0; seen = 1'b0;
    for (int k = 1; k <= 600 && !seen; k++) begin
      @(negedge clk);
`ifdef CNTSEQ_ABORT_EN
      abort = (ab > 0) && (k == ab);
`endif
      if (noise) begin
        cmd_valid = (k == 2);
        cmd_op    = 2'b01;
        cmd_arg   = 8'h55;
      end
      if (busy === 1'b1) nb++;
      if (done === 1'b1) begin seen = 1'b1; lat = k; end
    end
    cmd_valid = 1'b0; cmd_op = 2'b00;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s done_timeout got none want latency %0d", name, e_lat);
    end else if (lat != e_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, lat, e_lat);
    end
    checks++;
    if (nb != e_nb) begin
      errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, nb, e_nb);
    end
    checks++;
    if (int'(cnt) != e_fin) begin
      errors++; $display("FAIL %s counter got %02h want %02h", name, cnt, e_fin);
    end
    checks++;
    if (sat !== e_sat) begin
      errors++; $display("FAIL %s sat got %b want %b", name, sat, e_sat);
    end
`ifdef CNTSEQ_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_done got done=%b ready=%b want 0/1", name, done, cmd_ready);
    end
    mval = e_fin;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b busy=%b done=%b sat=%b want 1/0/0/0",
               cmd_ready, busy, done, sat);
    end
    checks++;
    if (ctr_load_n !== 1'b0 || ctr_preld !== cnt) begin
      errors++; $display("FAIL reset_freeze got load_n=%b preld=%02h want 0/%02h",
                         ctr_load_n, ctr_preld, cnt);
    end
    areset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (int'(cnt) != mval) begin
      errors++; $display("FAIL reset_hold counter got %02h want %02h", cnt, mval);
    end
  endtask

  task automatic test_directed();
    exec_cmd("load_3c",   2'b01, 8'h3C, 8'd0,  1'b0, 0, 1'b0);
    exec_cmd("up5_wrap",  2'b10, 8'h00, 8'd5,  1'b1, 0, 1'b0);
    exec_cmd("load_fa",   2'b01, 8'hFA, 8'd0,  1'b0, 0, 1'b0);
    exec_cmd("up10_stop", 2'b10, 8'h00, 8'd10, 1'b0, 0, 1'b0);
    exec_cmd("load_01",   2'b01, 8'h01, 8'd0,  1'b0, 0, 1'b0);
    exec_cmd("dn3_wrap",  2'b11, 8'h00, 8'd3,  1'b1, 0, 1'b0);
    exec_cmd("load_02",   2'b01, 8'h02, 8'd0,  1'b0, 0, 1'b0);
    exec_cmd("dn5_stop",  2'b11, 8'h00, 8'd5,  1'b0, 0, 1'b0);
    exec_cmd("nop",       2'b00, 8'h77, 8'd9,  1'b0, 0, 1'b0);
  endtask

  task automatic test_zero_and_ignore();
    int hold;
    exec_cmd("up0",        2'b10, 8'h00, 8'd0, 1'b1, 0, 1'b0);
    exec_cmd("up8_noise",  2'b10, 8'h00, 8'd8, 1'b1, 0, 1'b1);
    hold = int'(cnt);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (int'(cnt) != mval) begin
        errors++; $display("FAIL idle_stable cycle %0d got %02h want %02h", i, cnt, mval);
      end
    end
    if (hold != mval) mval = hold;
  endtask

  task automatic test_reset_mid_run();
    int held;
    exec_cmd("load_10", 2'b01, 8'h10, 8'd0, 1'b0, 0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_steps = 8'd50; cmd_wrap = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b00;
    repeat (5) @(negedge clk);
    areset_n = 1'b0;
    #1;
    held = (mval + 4) % 256;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrun_reset got ready=%b busy=%b done=%b want 1/0/0",
                         cmd_ready, busy, done);
    end
    checks++;
    if (int'(cnt) != held) begin
      errors++; $display("FAIL midrun_value got %02h want %02h", cnt, held);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (int'(cnt) != held || done !== 1'b0) begin
      errors++; $display("FAIL midrun_hold got %02h done=%b want %02h done=0", cnt, done, held);
    end
    areset_n = 1'b1;
    mval = held;
  endtask

`ifdef CNTSEQ_ABORT_EN
  task automatic test_abort();
    exec_cmd("load_80",   2'b01, 8'h80, 8'd0,  1'b0, 0, 1'b0);
    exec_cmd("abort_up",  2'b10, 8'h00, 8'd20, 1'b1, 4, 1'b0);
    exec_cmd("load_fd",   2'b01, 8'hFD, 8'd0,  1'b0, 0, 1'b0);
    exec_cmd("abort_lim", 2'b10, 8'h00, 8'd9,  1'b0, 3, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] arg, steps;
    bit         wrap;
    int         sel;
    for (int i = 0; i < 40; i++) begin
      op    = 2'($urandom_range(0, 3));
      sel   = int'($urandom_range(0, 2));
      arg   = (sel == 0) ? 8'($urandom) : (sel == 1) ? 8'(8'hF0 + 8'($urandom_range(0, 15)))
                                                     : 8'($urandom_range(0, 15));
      steps = 8'($urandom_range(0, 30));
      wrap  = 1'($urandom_range(0, 1));
      exec_cmd("random", op, arg, steps, wrap, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_and_ignore();
    test_reset_mid_run();
`ifdef CNTSEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
